// File: rtl/scr_wr_arbiter.sv
// Screen RAM write-port arbiter: buffered host writes plus a fill engine.
// One RAM write per clock, host first, with a starvation guard for the fill.
module scr_wr_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned MAX_HOST_RUN = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        host_wr,
    input  logic [15:0] host_addr,
    input  logic [7:0]  host_data,
    output logic        host_full,
    output logic        host_ovf,
    input  logic        ovf_clr,
    input  logic        fill_start,
    input  logic        fill_abort,
    input  logic [15:0] fill_base,
    input  logic [15:0] fill_len,
    input  logic [7:0]  fill_val,
    output logic        fill_busy,
    output logic        fill_done,
    output logic        ram_wren,
    output logic [15:0] ram_wraddress,
    output logic [7:0]  ram_data
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned RW = $clog2(MAX_HOST_RUN + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [RW-1:0] RUN_MAX = RW'(MAX_HOST_RUN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DONE
    } state_e;

    // Host write FIFO
    logic [23:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [CW-1:0] used_q, used_d;
    logic          ovf_q, ovf_d;

    // Fill engine
    state_e        state_q, state_d;
    logic [15:0]   base_q, base_d;
    logic [15:0]   len_q, len_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [7:0]    val_q, val_d;
    logic          zlen_q, zlen_d;
    logic          done_q, done_d;

    // Arbiter and registered RAM port
    logic [RW-1:0] run_q, run_d;
    logic          wren_q, wren_d;
    logic [15:0]   waddr_q, waddr_d;
    logic [7:0]    wdata_q, wdata_d;

    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          host_gnt;
    logic          fill_gnt;
    logic          fill_last;
    logic [23:0]   head;

    assign fifo_empty = (used_q == '0);
    assign host_full  = (used_q == DEPTH_C);
    assign head       = mem_q[rp_q];
    assign fill_last  = (cnt_q == len_q - 16'd1);

    assign host_gnt = !fifo_empty &&
                      ((state_q != S_FILL) || (run_q < RUN_MAX));
    assign fill_gnt = !host_gnt && (state_q == S_FILL);

    assign push = host_wr && !host_full;
    assign pop  = host_gnt;

    // FIFO pointers, occupancy and sticky overflow flag
    always_comb begin
        wp_d   = wp_q;
        rp_d   = rp_q;
        used_d = used_q + CW'(push) - CW'(pop);
        ovf_d  = ovf_q;
        if (push) begin
            wp_d = wp_q + PW'(1);
        end
        if (pop) begin
            rp_d = rp_q + PW'(1);
        end
        if (host_wr && host_full) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Fill FSM next state, region latch and completion pulse
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        zlen_d  = zlen_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (fill_start) begin
                    base_d  = fill_base;
                    len_d   = fill_len;
                    val_d   = fill_val;
                    cnt_d   = 16'd0;
                    zlen_d  = (fill_len == 16'd0);
                    state_d = (fill_len == 16'd0) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                if (fill_gnt) begin
                    cnt_d = cnt_q + 16'd1;
                end
                if (fill_abort) begin
                    state_d = S_IDLE;
                end else if (fill_gnt && fill_last) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = zlen_q && !fill_abort;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Host run length and the registered RAM write for this cycle's grant
    always_comb begin
        run_d   = run_q;
        wren_d  = host_gnt || fill_gnt;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if ((state_q != S_FILL) || fill_gnt) begin
            run_d = '0;
        end else if (host_gnt) begin
            run_d = run_q + RW'(1);
        end
        if (host_gnt) begin
            waddr_d = head[23:8];
            wdata_d = head[7:0];
        end else if (fill_gnt) begin
            waddr_d = base_q + cnt_q;
            wdata_d = val_q;
        end
    end

    // FIFO storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wp_q] <= {host_addr, host_data};
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            used_q  <= '0;
            ovf_q   <= 1'b0;
            state_q <= S_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            val_q   <= '0;
            zlen_q  <= 1'b0;
            done_q  <= 1'b0;
            run_q   <= '0;
            wren_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            used_q  <= used_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            zlen_q  <= zlen_d;
            done_q  <= done_d;
            run_q   <= run_d;
            wren_q  <= wren_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign host_ovf      = ovf_q;
    assign fill_busy     = (state_q != S_IDLE);
    assign fill_done     = done_q;
    assign ram_wren      = wren_q;
    assign ram_wraddress = waddr_q;
    assign ram_data      = wdata_q;

endmodule

// File: tb/tb_scr_wr_arbiter.sv
// Bench for scr_wr_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_scr_wr_arbiter;

    localparam int DEPTH  = 4;
    localparam int MAXRUN = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_wr = 1'b0;
    logic [15:0] host_addr = '0;
    logic [7:0]  host_data = '0;
    logic        host_full;
    logic        host_ovf;
    logic        ovf_clr = 1'b0;
    logic        fill_start = 1'b0;
    logic        fill_abort = 1'b0;
    logic [15:0] fill_base = '0;
    logic [15:0] fill_len = '0;
    logic [7:0]  fill_val = '0;
    logic        fill_busy;
    logic        fill_done;
    logic        ram_wren;
    logic [15:0] ram_wraddress;
    logic [7:0]  ram_data;

    int vectors = 0;
    int miscompares = 0;

    scr_wr_arbiter #(
        .FIFO_DEPTH  (DEPTH),
        .MAX_HOST_RUN(MAXRUN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .host_wr      (host_wr),
        .host_addr    (host_addr),
        .host_data    (host_data),
        .host_full    (host_full),
        .host_ovf     (host_ovf),
        .ovf_clr      (ovf_clr),
        .fill_start   (fill_start),
        .fill_abort   (fill_abort),
        .fill_base    (fill_base),
        .fill_len     (fill_len),
        .fill_val     (fill_val),
        .fill_busy    (fill_busy),
        .fill_done    (fill_done),
        .ram_wren     (ram_wren),
        .ram_wraddress(ram_wraddress),
        .ram_data     (ram_data)
    );

    always #5 clk = ~clk;

    // Reference model: pending host writes as a queue, the fill as
    // "next address / bytes left", outputs as the write made this cycle.
    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t         mq[$];
    int          m_mode;
    logic [15:0] m_next;
    int          m_left;
    logic [7:0]  m_val;
    bit          m_zero;
    int          m_run;
    bit          m_ovf;
    logic        m_wren;
    logic [15:0] m_addr;
    logic [7:0]  m_data;
    logic        m_done;

    function automatic void model_reset();
        mq.delete();
        m_mode = 0;
        m_next = '0;
        m_left = 0;
        m_val  = '0;
        m_zero = 1'b0;
        m_run  = 0;
        m_ovf  = 1'b0;
        m_wren = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_done = 1'b0;
    endfunction

    function automatic void model_step();
        bit  was_full;
        bit  hg;
        bit  fg;
        int  pre;
        wr_t w;
        was_full = (mq.size() == DEPTH);
        pre = m_mode;
        hg = (mq.size() != 0) && (m_mode != 1 || m_run < MAXRUN);
        fg = !hg && (m_mode == 1);
        m_wren = hg || fg;
        m_done = 1'b0;
        if (hg) begin
            w = mq.pop_front();
            m_addr = w.a;
            m_data = w.d;
        end
        if (fg) begin
            m_addr = m_next;
            m_data = m_val;
            m_next = m_next + 16'd1;
            m_left = m_left - 1;
        end
        if (host_wr && !was_full) mq.push_back({host_addr, host_data});
        if (host_wr && was_full) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        case (pre)
            0: if (fill_start) begin
                m_next = fill_base;
                m_left = int'(fill_len);
                m_val  = fill_val;
                m_zero = (fill_len == 16'd0);
                m_mode = m_zero ? 2 : 1;
            end
            1: if (fill_abort) m_mode = 0;
               else if (m_left == 0) begin
                   m_mode = 2;
                   m_done = 1'b1;
               end
            default: begin
                m_done = m_zero && !fill_abort;
                m_mode = 0;
            end
        endcase
        if (pre != 1 || fg) m_run = 0;
        else if (hg) m_run = m_run + 1;
    endfunction

    function automatic logic [28:0] model_out();
        return {m_wren, m_addr, m_data, m_mode != 0, m_done,
                mq.size() == DEPTH, m_ovf};
    endfunction

    function automatic logic [28:0] dut_out();
        return {ram_wren, ram_wraddress, ram_data, fill_busy, fill_done,
                host_full, host_ovf};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        host_wr    = 1'b0;
        fill_start = 1'b0;
        fill_abort = 1'b0;
        ovf_clr    = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (mq.size() != 0 || m_mode != 0); i++)
            tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (dut_out() !== 29'd0) begin
            miscompares++;
            $display("FAIL reset: got %h want 0", dut_out());
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (dut_out() !== model_out()) begin
            miscompares++;
            $display("FAIL reset_idle: got %h want %h", dut_out(), model_out());
        end
    endtask

    task automatic test_single_host();
        host_wr = 1'b1;
        host_addr = 16'h1234;
        host_data = 8'hA5;
        tick();
        vectors++;
        if (ram_wren !== 1'b0) begin
            miscompares++;
            $display("FAIL host_lat1: got wren %b want 0", ram_wren);
        end
        tick();
        vectors++;
        if ({ram_wren, ram_wraddress, ram_data} !== {1'b1, 16'h1234, 8'hA5}) begin
            miscompares++;
            $display("FAIL host_write: got %b %h %h want 1 1234 a5",
                     ram_wren, ram_wraddress, ram_data);
        end
        tick();
        vectors++;
        if ({ram_wren, ram_wraddress, ram_data} !== {1'b0, 16'h1234, 8'hA5}) begin
            miscompares++;
            $display("FAIL host_hold: got %b %h %h want 0 1234 a5",
                     ram_wren, ram_wraddress, ram_data);
        end
    endtask

    task automatic test_fill_wrap();
        logic [15:0] a;
        fill_start = 1'b1;
        fill_base = 16'hFFFE;
        fill_len = 16'd4;
        fill_val = 8'h20;
        tick();
        vectors++;
        if ({fill_busy, ram_wren} !== 2'b10) begin
            miscompares++;
            $display("FAIL fill_enter: got busy %b wren %b want 1 0",
                     fill_busy, ram_wren);
        end
        a = 16'hFFFE;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if ({ram_wren, ram_wraddress, ram_data, fill_busy, fill_done} !==
                {1'b1, a, 8'h20, 1'b1, i == 3}) begin
                miscompares++;
                $display("FAIL fill_wrap%0d: got %b %h %h b%b d%b want addr %h",
                         i, ram_wren, ram_wraddress, ram_data, fill_busy,
                         fill_done, a);
            end
            a = a + 16'd1;
        end
        tick();
        vectors++;
        if ({ram_wren, fill_busy, fill_done} !== 3'b000) begin
            miscompares++;
            $display("FAIL fill_end: got wren/busy/done %b%b%b want 000",
                     ram_wren, fill_busy, fill_done);
        end
    endtask

    task automatic test_zero_len();
        int writes;
        writes = 0;
        fill_start = 1'b1;
        fill_base = 16'h0200;
        fill_len = 16'd0;
        fill_val = 8'h11;
        tick();
        writes += int'(ram_wren);
        vectors++;
        if ({fill_busy, fill_done} !== 2'b10) begin
            miscompares++;
            $display("FAIL zero_c1: got busy %b done %b want 1 0",
                     fill_busy, fill_done);
        end
        tick();
        writes += int'(ram_wren);
        vectors++;
        if ({fill_busy, fill_done} !== 2'b01) begin
            miscompares++;
            $display("FAIL zero_c2: got busy %b done %b want 0 1",
                     fill_busy, fill_done);
        end
        tick();
        writes += int'(ram_wren);
        vectors++;
        if (fill_done !== 1'b0 || writes !== 0) begin
            miscompares++;
            $display("FAIL zero_c3: got done %b writes %0d want 0 0",
                     fill_done, writes);
        end
    endtask

    task automatic test_abort();
        int fills;
        fills = 0;
        fill_start = 1'b1;
        fill_base = 16'h0100;
        fill_len = 16'd10;
        fill_val = 8'h55;
        tick();
        tick();
        fills += int'(ram_wren);
        tick();
        fills += int'(ram_wren);
        fill_abort = 1'b1;
        tick();
        fills += int'(ram_wren);
        vectors++;
        if ({ram_wren, ram_wraddress, fill_busy} !== {1'b1, 16'h0102, 1'b0}) begin
            miscompares++;
            $display("FAIL abort_cycle: got %b %h busy %b want 1 0102 0",
                     ram_wren, ram_wraddress, fill_busy);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if ({ram_wren, fill_done, fill_busy} !== 3'b000) begin
                miscompares++;
                $display("FAIL abort_after%0d: got wren/done/busy %b%b%b want 000",
                         i, ram_wren, fill_done, fill_busy);
            end
        end
        vectors++;
        if (fills !== 3) begin
            miscompares++;
            $display("FAIL abort_count: got %0d fill writes want 3", fills);
        end
    endtask

    task automatic test_starvation();
        int hrun;
        int fills;
        hrun = 0;
        fills = 0;
        fill_start = 1'b1;
        fill_base = 16'h0040;
        fill_len = 16'd3;
        fill_val = 8'h3C;
        for (int i = 0; i < 40; i++) begin
            host_wr = (i < 30);
            host_addr = 16'h8000 | 16'($urandom);
            host_data = 8'($urandom);
            tick();
            vectors++;
            if (dut_out() !== model_out()) begin
                miscompares++;
                $display("FAIL starve_cyc%0d: got %h want %h",
                         i, dut_out(), model_out());
            end
            if (ram_wren) begin
                if (ram_wraddress[15]) hrun++;
                else begin
                    vectors++;
                    if (hrun !== MAXRUN) begin
                        miscompares++;
                        $display("FAIL starve_run: got %0d host writes want %0d",
                                 hrun, MAXRUN);
                    end
                    hrun = 0;
                    fills++;
                end
            end
        end
        vectors++;
        if (fills !== 3) begin
            miscompares++;
            $display("FAIL starve_fills: got %0d want 3", fills);
        end
    endtask

    task automatic test_overflow();
        fill_start = 1'b1;
        fill_base = 16'h0300;
        fill_len = 16'd300;
        fill_val = 8'h77;
        for (int i = 0; i < 60; i++) begin
            host_wr = 1'b1;
            host_addr = 16'($urandom);
            host_data = 8'($urandom);
            tick();
            vectors++;
            if (dut_out() !== model_out()) begin
                miscompares++;
                $display("FAIL ovf_cyc%0d: got %h want %h",
                         i, dut_out(), model_out());
            end
        end
        vectors++;
        if (host_ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_set: got %b want 1", host_ovf);
        end
        for (int i = 0; i < 20 && mq.size() != DEPTH; i++) begin
            host_wr = 1'b1;
            tick();
        end
        host_wr = 1'b1;
        ovf_clr = 1'b1;
        tick();
        vectors++;
        if (host_ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_set_wins: got %b want 1", host_ovf);
        end
        ovf_clr = 1'b1;
        tick();
        vectors++;
        if (host_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clr: got %b want 0", host_ovf);
        end
        fill_abort = 1'b1;
        tick();
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            host_wr    = ($urandom_range(0, 99) < 55);
            host_addr  = 16'($urandom);
            host_data  = 8'($urandom);
            fill_start = ($urandom_range(0, 99) < 6);
            fill_abort = ($urandom_range(0, 99) < 2);
            ovf_clr    = ($urandom_range(0, 99) < 5);
            fill_base  = 16'($urandom);
            fill_len   = 16'($urandom_range(0, 14));
            fill_val   = 8'($urandom);
            tick();
            vectors++;
            if (dut_out() !== model_out()) begin
                miscompares++;
                $display("FAIL random_cyc%0d: got %h want %h",
                         i, dut_out(), model_out());
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        fill_start = 1'b1;
        fill_base = 16'h0500;
        fill_len = 16'd50;
        fill_val = 8'h99;
        tick();
        for (int i = 0; i < 3; i++) begin
            host_wr = 1'b1;
            host_addr = 16'h4000 + 16'(i);
            host_data = 8'(i);
            tick();
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({ram_wren, fill_busy, fill_done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_mid: got wren/busy/done %b%b%b want 000",
                     ram_wren, fill_busy, fill_done);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if ({ram_wren, fill_busy, host_full} !== 3'b000) begin
                miscompares++;
                $display("FAIL reset_quiet%0d: got wren/busy/full %b%b%b want 000",
                         i, ram_wren, fill_busy, host_full);
            end
        end
        host_wr = 1'b1;
        host_addr = 16'hBEEF;
        host_data = 8'h42;
        tick();
        tick();
        vectors++;
        if (dut_out() !== model_out()) begin
            miscompares++;
            $display("FAIL reset_resume: got %h want %h", dut_out(), model_out());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_host();
        test_fill_wrap();
        test_zero_len();
        test_abort();
        test_starvation();
        test_overflow();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
